// File: rtl/xform_pkg.sv
// Shared constants, state encoding and saturation helper for the vertex transform stage.
// The optional clip-flag path is selected by the VTX_CLIP_EN macro in vertex_xform_unit.
package xform_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_FRAC_W = 16;
   localparam logic [DEF_DATA_W-1:0] FIX_ONE = DEF_DATA_W'(1) << DEF_FRAC_W;
   localparam int SAT_MAX_W  = 128;

   typedef enum logic [2:0] {IDLE, ROW0, ROW1, ROW2, ROW3} xform_state_e;

   localparam int CLIP_W     = 6;
   localparam int CLIP_X_POS = 0;
   localparam int CLIP_X_NEG = 1;
   localparam int CLIP_Y_POS = 2;
   localparam int CLIP_Y_NEG = 3;
   localparam int CLIP_Z_POS = 4;
   localparam int CLIP_Z_NEG = 5;

   // Clamp a wide signed value into the signed range of 'width' bits.
   function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
      input logic signed [SAT_MAX_W-1:0] val,
      input int width
   );
      logic signed [SAT_MAX_W-1:0] max_v;
      logic signed [SAT_MAX_W-1:0] min_v;
      max_v = (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
      min_v = ~max_v;
      if (val > max_v) return max_v;
      if (val < min_v) return min_v;
      return val;
   endfunction

endpackage

// File: rtl/xform_fifo.sv
// Parametrised synchronous FIFO holding transformed vertices; head is read straight from
// storage registers so it stays stable until popped.
module xform_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_valid = (count != '0);
   assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/vertex_xform_unit.sv
// Fixed-point 4x4 vertex transform: one matrix row per cycle, results queued in an output FIFO.
// Define VTX_CLIP_EN to compute clip flags and carry them through the FIFO with each vertex.
module vertex_xform_unit
   import xform_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FRAC_W     = DEF_FRAC_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mat_wr_en,
   input  logic [1:0]            mat_wr_row,
   input  logic [4*DATA_W-1:0]   mat_wr_data,
   input  logic                  mat_load_id,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DATA_W-1:0]   in_vertex,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DATA_W-1:0]   out_vertex,
   output logic [5:0]            out_clip,
   output logic                  busy
);
   localparam int ACC_W = DATA_W + FRAC_W + 2;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic signed [DATA_W-1:0] ONE_FX = DATA_W'(1) << FRAC_W;
`ifdef VTX_CLIP_EN
   localparam int FIFO_W = 4*DATA_W + CLIP_W;
`else
   localparam int FIFO_W = 4*DATA_W;
`endif

   xform_state_e             state_q;
   xform_state_e             state_d;
   logic signed [DATA_W-1:0] mat [4][4];
   logic signed [DATA_W-1:0] vtx [4];
   logic signed [DATA_W-1:0] res [3];
   logic [1:0]               row_idx;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] row_result;
   logic                     accept;
   logic                     push;
   logic                     pop;
   logic [CNT_W-1:0]         fifo_count;
   logic [FIFO_W-1:0]        push_data;
   logic [FIFO_W-1:0]        head_data;

   // FIFO space is checked at accept, so the push four cycles later can never overflow.
   assign busy     = (state_q != IDLE);
   assign in_ready = (state_q == IDLE) && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign accept   = in_valid && in_ready;
   assign push     = (state_q == ROW3);
   assign pop      = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      row_idx = 2'd0;
      case (state_q)
         IDLE: if (accept) state_d = ROW0;
         ROW0: begin state_d = ROW1; row_idx = 2'd0; end
         ROW1: begin state_d = ROW2; row_idx = 2'd1; end
         ROW2: begin state_d = ROW3; row_idx = 2'd2; end
         ROW3: begin state_d = IDLE; row_idx = 2'd3; end
         default: state_d = IDLE;
      endcase
   end

   // Each product is floored back to the fixed-point scale before accumulation.
   always_comb begin
      acc = '0;
      for (int k = 0; k < 4; k++) begin
         acc = acc + ACC_W'(((2*DATA_W)'(mat[row_idx][k]) * (2*DATA_W)'(vtx[k])) >>> FRAC_W);
      end
   end

   assign row_result = DATA_W'(sat_signed(SAT_MAX_W'(acc), DATA_W));

   // Matrix updates only land while idle, so an in-flight vertex always sees one matrix.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               mat[i][j] <= (i == j) ? ONE_FX : '0;
         for (int k = 0; k < 4; k++) vtx[k] <= '0;
         for (int r = 0; r < 3; r++) res[r] <= '0;
      end else begin
         if (state_q == IDLE) begin
            if (mat_load_id) begin
               for (int i = 0; i < 4; i++)
                  for (int j = 0; j < 4; j++)
                     mat[i][j] <= (i == j) ? ONE_FX : '0;
            end else if (mat_wr_en) begin
               for (int k = 0; k < 4; k++)
                  mat[mat_wr_row][k] <= mat_wr_data[(3-k)*DATA_W +: DATA_W];
            end
         end
         if (accept)
            for (int k = 0; k < 4; k++) vtx[k] <= in_vertex[(3-k)*DATA_W +: DATA_W];
         if (state_q == ROW0) res[0] <= row_result;
         if (state_q == ROW1) res[1] <= row_result;
         if (state_q == ROW2) res[2] <= row_result;
      end
   end

`ifdef VTX_CLIP_EN
   logic signed [DATA_W-1:0] neg_w;
   logic [CLIP_W-1:0]        clip_flags;

   // -w is saturated so the most negative w still yields a representable bound.
   always_comb begin
      neg_w      = DATA_W'(sat_signed(-SAT_MAX_W'(row_result), DATA_W));
      clip_flags = '0;
      clip_flags[CLIP_X_POS] = (res[0] > row_result);
      clip_flags[CLIP_X_NEG] = (res[0] < neg_w);
      clip_flags[CLIP_Y_POS] = (res[1] > row_result);
      clip_flags[CLIP_Y_NEG] = (res[1] < neg_w);
      clip_flags[CLIP_Z_POS] = (res[2] > row_result);
      clip_flags[CLIP_Z_NEG] = (res[2] < neg_w);
   end

   assign push_data  = {res[0], res[1], res[2], row_result, clip_flags};
   assign out_vertex = head_data[FIFO_W-1 -: 4*DATA_W];
   assign out_clip   = head_data[CLIP_W-1:0];
`else
   assign push_data  = {res[0], res[1], res[2], row_result};
   assign out_vertex = head_data;
   assign out_clip   = 6'b0;
`endif

   xform_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .head_data  (head_data),
      .head_valid (out_valid),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_vertex_xform_unit.sv
// Bench for vertex_xform_unit: a longint reference model predicts each vertex at accept,
// and a scoreboard compares it when the FIFO head is popped. Honours VTX_CLIP_EN.
`timescale 1ns/1ps
module tb_vertex_xform_unit;
   import xform_pkg::*;

   localparam int DW    = 32;
   localparam int FW    = 16;
   localparam int DEPTH = 4;
   localparam logic signed [DW-1:0] ONE = FIX_ONE;

   typedef struct {
      logic [4*DW-1:0] vtx;
      logic [5:0]      clip;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            mat_wr_en;
   logic [1:0]      mat_wr_row;
   logic [4*DW-1:0] mat_wr_data;
   logic            mat_load_id;
   logic            in_valid;
   logic            in_ready;
   logic [4*DW-1:0] in_vertex;
   logic            out_valid;
   logic            out_ready;
   logic [4*DW-1:0] out_vertex;
   logic [5:0]      out_clip;
   logic            busy;

   exp_t                  sb_q[$];
   logic signed [DW-1:0]  tb_mat [4][4];
   int                    checks = 0;
   int                    fails = 0;
   int                    cycle = 0;
   int                    last_accept = 0;

   vertex_xform_unit #(
      .DATA_W     (DW),
      .FRAC_W     (FW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mat_wr_en   (mat_wr_en),
      .mat_wr_row  (mat_wr_row),
      .mat_wr_data (mat_wr_data),
      .mat_load_id (mat_load_id),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_vertex   (in_vertex),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_vertex  (out_vertex),
      .out_clip    (out_clip),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic signed [DW-1:0] sat_model(input longint v);
      longint hi;
      longint lo;
      hi = 64'sd2147483647;
      lo = -64'sd2147483648;
      if (v > hi) return 32'sh7FFF_FFFF;
      if (v < lo) return 32'sh8000_0000;
      return v[31:0];
   endfunction

   function automatic exp_t predict(input logic [4*DW-1:0] vin);
      logic signed [DW-1:0] v [4];
      logic signed [DW-1:0] r [4];
      longint sum;
      exp_t e;
`ifdef VTX_CLIP_EN
      logic signed [DW-1:0] nw;
`endif
      for (int k = 0; k < 4; k++) v[k] = vin[(3-k)*DW +: DW];
      for (int i = 0; i < 4; i++) begin
         sum = 0;
         for (int k = 0; k < 4; k++) sum += (longint'(tb_mat[i][k]) * longint'(v[k])) >>> FW;
         r[i] = sat_model(sum);
      end
      e.vtx  = {r[0], r[1], r[2], r[3]};
      e.clip = 6'b0;
`ifdef VTX_CLIP_EN
      nw = sat_model(-longint'(r[3]));
      e.clip[0] = (r[0] > r[3]);
      e.clip[1] = (r[0] < nw);
      e.clip[2] = (r[1] > r[3]);
      e.clip[3] = (r[1] < nw);
      e.clip[4] = (r[2] > r[3]);
      e.clip[5] = (r[2] < nw);
`endif
      return e;
   endfunction

   function automatic logic signed [DW-1:0] rand_fx(input int bits);
      int r;
      r = int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
      return r;
   endfunction

   function automatic logic [4*DW-1:0] rand_vertex();
      return {rand_fx(23), rand_fx(23), rand_fx(23), ONE + rand_fx(18)};
   endfunction

   // Scoreboard: every pop of the FIFO head is checked against the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_output got=%h required=none", out_vertex);
         end else begin
            e = sb_q.pop_front();
            checks++;
            if (out_vertex !== e.vtx) begin
               fails++;
               $display("[TB] FAIL out_vertex got=%h required=%h", out_vertex, e.vtx);
            end
            checks++;
            if (out_clip !== e.clip) begin
               fails++;
               $display("[TB] FAIL out_clip got=%b required=%b", out_clip, e.clip);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic model_identity();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            tb_mat[i][j] = (i == j) ? ONE : '0;
   endtask

   task automatic write_row(input int row, input logic signed [DW-1:0] c0, c1, c2, c3);
      mat_wr_en   = 1'b1;
      mat_wr_row  = 2'(row);
      mat_wr_data = {c0, c1, c2, c3};
      tb_mat[row][0] = c0;
      tb_mat[row][1] = c1;
      tb_mat[row][2] = c2;
      tb_mat[row][3] = c3;
      tick();
      mat_wr_en = 1'b0;
   endtask

   task automatic load_identity();
      mat_load_id = 1'b1;
      model_identity();
      tick();
      mat_load_id = 1'b0;
   endtask

   task automatic send_vertex(input logic [4*DW-1:0] vin);
      int waited;
      waited    = 0;
      in_valid  = 1'b1;
      in_vertex = vin;
      @(negedge clk);
      while (in_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL accept_timeout in_ready=%b required=1", in_ready);
      end else begin
         sb_q.push_back(predict(vin));
      end
      tick();
      last_accept = cycle;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy !== 1'b0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      tick();
      checks++;
      if (sb_q.size() != 0 || out_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL drain pending=%0d out_valid=%b required pending=0 out_valid=0",
                  sb_q.size(), out_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got=%b required=0", out_valid); end
      checks++;
      if (out_vertex !== '0) begin fails++; $display("[TB] FAIL reset_out_vertex got=%h required=0", out_vertex); end
      checks++;
      if (out_clip !== 6'b0) begin fails++; $display("[TB] FAIL reset_out_clip got=%b required=0", out_clip); end
      checks++;
      if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got=%b required=0", busy); end
      model_identity();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_identity();
      out_ready = 1'b1;
      send_vertex({32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000});
      checks++;
      if (busy !== 1'b1) begin fails++; $display("[TB] FAIL busy_after_accept got=%b required=1", busy); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (c == 4)) begin
            fails++;
            $display("[TB] FAIL latency cycle=%0d out_valid=%b required=%b", c, out_valid, (c == 4));
         end
      end
      wait_drain();
   endtask

   task automatic test_translation();
      write_row(0, ONE, 32'sh0, 32'sh0, 32'sh0005_0000);
      send_vertex({32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000});
      wait_drain();
      load_identity();
   endtask

   task automatic test_saturation();
      write_row(0, 32'sh7FFF_0000, 32'sh0, 32'sh0, 32'sh0);
      send_vertex({32'h0002_0000, 32'h0, 32'h0, 32'h0001_0000});
      wait_drain();
      write_row(0, 32'sh8000_0000, 32'sh0, 32'sh0, 32'sh0);
      send_vertex({32'h0002_0000, 32'h0, 32'h0, 32'h0001_0000});
      wait_drain();
      load_identity();
   endtask

   task automatic test_priority_and_same_cycle_write();
      mat_load_id = 1'b1;
      mat_wr_en   = 1'b1;
      mat_wr_row  = 2'd1;
      mat_wr_data = '0;
      model_identity();
      tick();
      mat_load_id = 1'b0;
      mat_wr_en   = 1'b0;
      send_vertex(rand_vertex());
      wait_drain();
      mat_wr_en   = 1'b1;
      mat_wr_row  = 2'd2;
      mat_wr_data = {32'sh0, 32'sh0, 32'sh0002_0000, 32'sh0003_0000};
      tb_mat[2][0] = 32'sh0;
      tb_mat[2][1] = 32'sh0;
      tb_mat[2][2] = 32'sh0002_0000;
      tb_mat[2][3] = 32'sh0003_0000;
      send_vertex(rand_vertex());
      mat_wr_en = 1'b0;
      wait_drain();
   endtask

   task automatic test_backpressure();
      logic [4*DW-1:0] v5;
      int ready_seen;
      for (int r = 0; r < 4; r++) write_row(r, rand_fx(18), rand_fx(18), rand_fx(18), rand_fx(18));
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_vertex(rand_vertex());
      v5 = rand_vertex();
      in_valid   = 1'b1;
      in_vertex  = v5;
      ready_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (in_ready !== 1'b0) ready_seen++;
      end
      checks++;
      if (ready_seen != 0) begin fails++; $display("[TB] FAIL full_in_ready cycles_high=%0d required=0", ready_seen); end
      checks++;
      if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL full_out_valid got=%b required=1", out_valid); end
      tick();
      out_ready = 1'b1;
      send_vertex(v5);
      wait_drain();
   endtask

   task automatic test_write_while_busy();
      send_vertex(rand_vertex());
      tick();
      mat_wr_en   = 1'b1;
      mat_wr_row  = 2'd0;
      mat_wr_data = '0;
      checks++;
      if (busy !== 1'b1) begin fails++; $display("[TB] FAIL busy_row1 got=%b required=1", busy); end
      tick();
      mat_wr_en = 1'b0;
      send_vertex(rand_vertex());
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int first;
      out_ready = 1'b1;
      send_vertex(rand_vertex());
      first = last_accept;
      send_vertex(rand_vertex());
      checks++;
      if (last_accept - first != 5) begin fails++; $display("[TB] FAIL throughput gap=%0d required=5", last_accept - first); end
      first = last_accept;
      send_vertex(rand_vertex());
      checks++;
      if (last_accept - first != 5) begin fails++; $display("[TB] FAIL throughput gap=%0d required=5", last_accept - first); end
      wait_drain();
   endtask

   task automatic test_reset_mid();
      write_row(0, ONE, 32'sh0, 32'sh0, 32'sh0005_0000);
      out_ready = 1'b0;
      send_vertex(rand_vertex());
      repeat (5) tick();
      send_vertex(rand_vertex());
      tick();
      reset = 1'b0;
      #1;
      sb_q.delete();
      model_identity();
      checks++;
      if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midreset_busy got=%b required=0", busy); end
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset_out_valid got=%b required=0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midreset_in_ready got=%b required=1", in_ready); end
      tick();
      reset     = 1'b1;
      out_ready = 1'b1;
      tick();
      send_vertex({32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000});
      wait_drain();
   endtask

   task automatic test_clip();
      load_identity();
      send_vertex({32'h0002_0000, 32'h0, 32'h0, 32'h0001_0000});
      send_vertex({32'hFFFE_0000, 32'h0, 32'h0, 32'h0001_0000});
      send_vertex({32'h0, 32'h0003_0000, 32'hFFFC_0000, 32'h0002_0000});
      wait_drain();
   endtask

   initial begin
      reset       = 1'b0;
      mat_wr_en   = 1'b0;
      mat_wr_row  = 2'd0;
      mat_wr_data = '0;
      mat_load_id = 1'b0;
      in_valid    = 1'b0;
      in_vertex   = '0;
      out_ready   = 1'b0;
      test_reset();
      test_identity();
      test_translation();
      test_saturation();
      test_priority_and_same_cycle_write();
      test_backpressure();
      test_write_while_busy();
      test_back_to_back();
      test_reset_mid();
      test_clip();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
